memreq_queue: RTL and testbench
===============================

MEMREQ_QUEUE -- requirements
Module: memreq_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter AW, default 39, meaning request address width.
REQ-003 SHALL have parameter DW, default 533 (8*66+5), meaning write data width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  a request is presented.
REQ-007 SHALL have port in_ready  output  1  the queue accepts a request this cycle.
REQ-008 SHALL have port in_rd  input  1  the request contains a read.
REQ-009 SHALL have port in_wr  input  1  the request contains a write.
REQ-010 SHALL have port in_addr  input  AW  read address.
REQ-011 SHALL have port in_waddr  input  AW  write address.
REQ-012 SHALL have port in_wdata  input  DW  write data.
REQ-013 SHALL have port stall  input  1  memory-stage stall; when high, the downstream stage does not consume.
REQ-014 SHALL have ports rden_in, wren_in  output  1 each  registered issue strobes to the memory stage.
REQ-015 SHALL have ports rdaddr0, wraddr0  output  AW each; and port wrdata  output  DW; all registered.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Handshake: a request SHALL be transferred on a rising edge with in_valid=1, in_ready=1 and (in_rd|in_wr)=1.
REQ-018 in_valid=1 with in_rd=in_wr=0 SHALL be discarded: no state change.
REQ-019 in_ready SHALL equal (count<DEPTH), independent of a same-cycle pop.
REQ-020 Each FIFO entry SHALL hold {rd, wr, addr, waddr, wdata}; issue order SHALL equal acceptance order.
REQ-021 Output register update: when stall=0, outputs SHALL load the FIFO head and pop it; if the FIFO is empty, rden_in and wren_in SHALL go to 0.
REQ-022 When stall=1, all outputs SHALL hold their values; no pop SHALL occur; pushes SHALL continue while in_ready=1.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH-1.
REQ-024 A pop of the last entry concurrent with a push SHALL issue the older entry and retain the new one.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; count SHALL saturate at neither 0 nor DEPTH beyond legal use, because push is blocked at full and pop at empty.
REQ-026 Without bypass, accept-to-issue latency SHALL be 2 cycles minimum: accept at edge N, pop at edge N+1, output visible after N+1.
REQ-027 Idle output values: addresses and data SHALL retain the last issued values; only the strobes SHALL be cleared.

Reset
REQ-028 When rst=0, the block SHALL clear count, both pointers, rden_in and wren_in to 0 immediately, independent of clk.
REQ-029 When rst=0, the block SHALL clear rdaddr0, wraddr0 and wrdata to 0; FIFO storage need not be cleared.
REQ-030 Reset asserted mid-operation SHALL drop all queued and in-flight requests; in_ready SHALL be 1 on the first edge after deassertion.

Configuration
REQ-031 Macro MEMREQ_BYPASS_EN, when defined, SHALL load the request directly into the output register at the accepting edge if count=0 and stall=0, giving 1-cycle latency; the request SHALL not be enqueued.
REQ-032 Without MEMREQ_BYPASS_EN, every request SHALL pass through the FIFO per REQ-026.

Verification
REQ-033 Scenario: single read addr=0x12345, stall=0, empty queue -> rden_in=1, rdaddr0=0x12345 two cycles after accept (one with bypass), for one cycle.
REQ-034 Scenario: push 8 writes with stall=1 -> count=8, in_ready=0; release stall -> 8 consecutive wren_in pulses, wraddr0 in push order.
REQ-035 Scenario: count=8, stall=0, in_valid=1 -> no accept that cycle; count goes 7; next push is accepted.
REQ-036 Scenario: count=3, push and pop on the same edge -> count stays 3; issued entry is the oldest.
REQ-037 Scenario: in_rd=in_wr=1, addr=0x40, waddr=0x80 -> rden_in=wren_in=1 in the same cycle, rdaddr0=0x40, wraddr0=0x80.
REQ-038 Scenario: rst low with 5 entries queued and stall=1 -> count=0, strobes=0 immediately; no issue after release.

Source files
------------

// File: rtl/memreq_queue.sv
// memreq_queue: in-order memory request FIFO feeding a registered issue stage.
// Accepted read/write requests are queued and issued one per cycle into the
// output register whenever the memory stage is not stalled.
// Optional feature: define MEMREQ_BYPASS_EN to load a request straight into the
// output register when the queue is empty and the stage is not stalled.
module memreq_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 39,
    parameter int unsigned DW    = 533
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_rd,
    input  logic                       in_wr,
    input  logic [AW-1:0]              in_addr,
    input  logic [AW-1:0]              in_waddr,
    input  logic [DW-1:0]              in_wdata,
    input  logic                       stall,
    output logic                       rden_in,
    output logic                       wren_in,
    output logic [AW-1:0]              rdaddr0,
    output logic [AW-1:0]              wraddr0,
    output logic [DW-1:0]              wrdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } entry_t;

    // Storage is not reset; only occupied slots are ever read out.
    entry_t mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            rden_q, rden_d;
    logic            wren_q, wren_d;
    logic [AW-1:0]   rdaddr_q, rdaddr_d;
    logic [AW-1:0]   wraddr_q, wraddr_d;
    logic [DW-1:0]   wrdata_q, wrdata_d;

    logic   req_fire;
    logic   push;
    logic   pop;
    logic   bypass;
    entry_t in_entry;
    entry_t head;

    // Handshake decode: push/pop/bypass qualification for this cycle.
    always_comb begin
        in_entry = '{rd: in_rd, wr: in_wr, addr: in_addr, waddr: in_waddr, wdata: in_wdata};
        head     = mem_q[rd_ptr_q];
        // Ready depends only on occupancy, never on a same-cycle pop.
        in_ready = (count_q < CntW'(DEPTH));
        // Requests carrying neither a read nor a write are dropped.
        req_fire = in_valid & in_ready & (in_rd | in_wr);
        pop      = ~stall & (count_q != '0);
`ifdef MEMREQ_BYPASS_EN
        bypass   = req_fire & (count_q == '0) & ~stall;
`else
        bypass   = 1'b0;
`endif
        push     = req_fire & ~bypass;
    end

    // Next-state for pointers, occupancy and the issue register.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
        rden_d   = rden_q;
        wren_d   = wren_q;
        rdaddr_d = rdaddr_q;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        if (!stall) begin
            if (pop) begin
                rden_d   = head.rd;
                wren_d   = head.wr;
                rdaddr_d = head.addr;
                wraddr_d = head.waddr;
                wrdata_d = head.wdata;
            end else if (bypass) begin
                rden_d   = in_entry.rd;
                wren_d   = in_entry.wr;
                rdaddr_d = in_entry.addr;
                wraddr_d = in_entry.waddr;
                wrdata_d = in_entry.wdata;
            end else begin
                // Idle: drop strobes, keep last issued address/data.
                rden_d = 1'b0;
                wren_d = 1'b0;
            end
        end
    end

    // Control and issue-register state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rden_q   <= 1'b0;
            wren_q   <= 1'b0;
            rdaddr_q <= '0;
            wraddr_q <= '0;
            wrdata_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rden_q   <= rden_d;
            wren_q   <= wren_d;
            rdaddr_q <= rdaddr_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign rden_in = rden_q;
    assign wren_in = wren_q;
    assign rdaddr0 = rdaddr_q;
    assign wraddr0 = wraddr_q;
    assign wrdata  = wrdata_q;
    assign count   = count_q;

endmodule

// File: tb/tb_memreq_queue.sv
// Directed self-checking bench for memreq_queue (default DEPTH/AW/DW).
module tb_memreq_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 39;
    localparam int unsigned DW    = 533;
`ifdef MEMREQ_BYPASS_EN
    localparam int Lat = 1;
`else
    localparam int Lat = 2;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_rd;
    logic                  in_wr;
    logic [AW-1:0]         in_addr;
    logic [AW-1:0]         in_waddr;
    logic [DW-1:0]         in_wdata;
    logic                  stall;
    logic                  rden_in;
    logic                  wren_in;
    logic [AW-1:0]         rdaddr0;
    logic [AW-1:0]         wraddr0;
    logic [DW-1:0]         wrdata;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    memreq_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rd    (in_rd),
        .in_wr    (in_wr),
        .in_addr  (in_addr),
        .in_waddr (in_waddr),
        .in_wdata (in_wdata),
        .stall    (stall),
        .rden_in  (rden_in),
        .wren_in  (wren_in),
        .rdaddr0  (rdaddr0),
        .wraddr0  (wraddr0),
        .wrdata   (wrdata),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        in_valid = 1'b0;
        in_rd    = 1'b0;
        in_wr    = 1'b0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        in_valid = 1'b1;
        in_rd    = rd;
        in_wr    = wr;
        in_addr  = a;
        in_waddr = wa;
        in_wdata = wd;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stall = 1'b0;
        idle();
        in_addr = '0; in_waddr = '0; in_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (count !== 4'd0 || rden_in !== 1'b0 || wren_in !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: count=%0d rden=%b wren=%b, required 0 0 0",
                     count, rden_in, wren_in);
        end
        checks++;
        if (rdaddr0 !== '0 || wraddr0 !== '0 || wrdata !== '0) begin
            errors++;
            $display("FAIL reset_data: rdaddr0=%h wraddr0=%h, required 0 0 (wrdata 0)",
                     rdaddr0, wraddr0);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        drive(1'b1, 1'b0, AW'(39'h12345), '0, '0);
        @(negedge clk);
        idle();
        if (Lat == 2) begin
            checks++;
            if (rden_in !== 1'b0 || count !== 4'd1) begin
                errors++;
                $display("FAIL sr_queued: rden=%b count=%0d, required 0 1", rden_in, count);
            end
            @(negedge clk);
        end
        checks++;
        if (rden_in !== 1'b1 || rdaddr0 !== AW'(39'h12345) || wren_in !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL sr_issue: rden=%b wren=%b rdaddr0=%h count=%0d, required 1 0 12345 0",
                     rden_in, wren_in, rdaddr0, count);
        end
        @(negedge clk);
        checks++;
        if (rden_in !== 1'b0 || rdaddr0 !== AW'(39'h12345)) begin
            errors++;
            $display("FAIL sr_idle: rden=%b rdaddr0=%h, required 0 12345", rden_in, rdaddr0);
        end
    endtask

    task automatic test_discard();
        drive(1'b0, 1'b0, AW'(39'h777), AW'(39'h888), '0);
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++;
        if (count !== 4'd0 || rden_in !== 1'b0 || wren_in !== 1'b0) begin
            errors++;
            $display("FAIL discard: count=%0d rden=%b wren=%b, required 0 0 0",
                     count, rden_in, wren_in);
        end
    endtask

    // Fill to DEPTH under stall, then release with a request pending at full.
    task automatic test_fill_drain();
        stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, '0, AW'(32'h100 + i), DW'(i + 1));
            @(negedge clk);
        end
        idle();
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0 || wren_in !== 1'b0) begin
            errors++;
            $display("FAIL full: count=%0d in_ready=%b wren=%b, required 8 0 0",
                     count, in_ready, wren_in);
        end
        stall = 1'b0;
        drive(1'b0, 1'b1, '0, AW'(32'h1FF), DW'(99));
        @(negedge clk);
        checks++;
        if (count !== 4'd7 || wren_in !== 1'b1 || wraddr0 !== AW'(32'h100) ||
            wrdata !== DW'(1) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: count=%0d wren=%b wraddr0=%h ready=%b, required 7 1 100 1",
                     count, wren_in, wraddr0, in_ready);
        end
        @(negedge clk);
        idle();
        checks++;
        if (count !== 4'd7 || wren_in !== 1'b1 || wraddr0 !== AW'(32'h101) || wrdata !== DW'(2)) begin
            errors++;
            $display("FAIL full_pushpop: count=%0d wren=%b wraddr0=%h, required 7 1 101",
                     count, wren_in, wraddr0);
        end
        for (int k = 2; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (wren_in !== 1'b1 || wraddr0 !== AW'(32'h100 + k) || wrdata !== DW'(k + 1)) begin
                errors++;
                $display("FAIL drain_%0d: wren=%b wraddr0=%h, required 1 %h",
                         k, wren_in, wraddr0, 32'h100 + k);
            end
        end
        @(negedge clk);
        checks++;
        if (wren_in !== 1'b1 || wraddr0 !== AW'(32'h1FF) || wrdata !== DW'(99)) begin
            errors++;
            $display("FAIL drain_late: wren=%b wraddr0=%h, required 1 1ff", wren_in, wraddr0);
        end
        @(negedge clk);
        checks++;
        if (wren_in !== 1'b0 || count !== 4'd0 || wraddr0 !== AW'(32'h1FF)) begin
            errors++;
            $display("FAIL drain_end: wren=%b count=%0d wraddr0=%h, required 0 0 1ff",
                     wren_in, count, wraddr0);
        end
    endtask

    // Queue n entries under stall, then push and pop on the same edge.
    task automatic test_push_pop(input int n);
        stall = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, AW'(32'h10 + i), '0, '0);
            @(negedge clk);
        end
        stall = 1'b0;
        drive(1'b1, 1'b0, AW'(32'h10 + n), '0, '0);
        @(negedge clk);
        idle();
        checks++;
        if (count !== 4'(n) || rden_in !== 1'b1 || rdaddr0 !== AW'(32'h10)) begin
            errors++;
            $display("FAIL pushpop_%0d: count=%0d rden=%b rdaddr0=%h, required %0d 1 10",
                     n, count, rden_in, rdaddr0, n);
        end
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            checks++;
            if (rden_in !== 1'b1 || rdaddr0 !== AW'(32'h10 + k)) begin
                errors++;
                $display("FAIL pp_order_%0d_%0d: rden=%b rdaddr0=%h, required 1 %h",
                         n, k, rden_in, rdaddr0, 32'h10 + k);
            end
        end
        @(negedge clk);
        checks++;
        if (rden_in !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL pp_end_%0d: rden=%b count=%0d, required 0 0", n, rden_in, count);
        end
    endtask

    task automatic test_rd_wr_both();
        drive(1'b1, 1'b1, AW'(32'h40), AW'(32'h80), DW'(32'hDEADBEEF));
        @(negedge clk);
        idle();
        if (Lat == 2) @(negedge clk);
        checks++;
        if (rden_in !== 1'b1 || wren_in !== 1'b1 || rdaddr0 !== AW'(32'h40) ||
            wraddr0 !== AW'(32'h80) || wrdata !== DW'(32'hDEADBEEF)) begin
            errors++;
            $display("FAIL rdwr: rden=%b wren=%b rdaddr0=%h wraddr0=%h, required 1 1 40 80",
                     rden_in, wren_in, rdaddr0, wraddr0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        stall = 1'b0;
        drive(1'b1, 1'b0, AW'(32'h55), '0, '0);
        @(negedge clk);
        idle();
        if (Lat == 2) @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, AW'(32'h200 + i), AW'(32'h300 + i), DW'(i));
            @(negedge clk);
        end
        idle();
        checks++;
        if (count !== 4'd5 || rden_in !== 1'b1 || rdaddr0 !== AW'(32'h55)) begin
            errors++;
            $display("FAIL pre_rst: count=%0d rden=%b rdaddr0=%h, required 5 1 55",
                     count, rden_in, rdaddr0);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || rden_in !== 1'b0 || wren_in !== 1'b0 || rdaddr0 !== '0) begin
            errors++;
            $display("FAIL async_rst: count=%0d rden=%b wren=%b rdaddr0=%h, required 0 0 0 0",
                     count, rden_in, wren_in, rdaddr0);
        end
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: in_ready=%b, required 1", in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (rden_in !== 1'b0 || wren_in !== 1'b0 || count !== 4'd0) begin
                errors++;
                $display("FAIL post_rst_%0d: rden=%b wren=%b count=%0d, required 0 0 0",
                         k, rden_in, wren_in, count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_discard();
        test_fill_drain();
        test_push_pop(3);
        test_push_pop(7);
        test_rd_wr_both();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
